// File: rtl/beat_pkg.sv
// Shared types for the beat timer: controller state, beat and phase
// encodings, plus the one-hot decoders that drive the t/w output lines.
package beat_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        B_W1 = 2'd0,
        B_W2 = 2'd1,
        B_W3 = 2'd2
    } beat_t;

    typedef enum logic [1:0] {
        P_T1 = 2'd0,
        P_T2 = 2'd1,
        P_T3 = 2'd2
    } phase_t;

    // Bit 0 is w1, bit 2 is w3.
    function automatic logic [2:0] beat_onehot(beat_t b);
        logic [2:0] oh;
        oh = 3'b000;
        case (b)
            B_W1:    oh = 3'b001;
            B_W2:    oh = 3'b010;
            B_W3:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Bit 0 is t1, bit 2 is t3.
    function automatic logic [2:0] phase_onehot(phase_t p);
        logic [2:0] oh;
        oh = 3'b000;
        case (p)
            P_T1:    oh = 3'b001;
            P_T2:    oh = 3'b010;
            P_T3:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/beat_timer_if.sv
// Controller-facing bundle of the beat timer.
//   short, long, stop : controller requests, sampled at the decision clk
//   t1..t3            : one-hot phase pulses
//   w1..w3            : one-hot beat levels
//   running           : timer is in RUN
//   int_pulse         : conditioned interrupt pulse
// master = hardwired controller, slave = beat timer.
interface beat_timer_if;

    logic short;
    logic long;
    logic stop;
    logic t1;
    logic t2;
    logic t3;
    logic w1;
    logic w2;
    logic w3;
    logic running;
    logic int_pulse;

    modport master (
        output short, long, stop,
        input  t1, t2, t3, w1, w2, w3, running, int_pulse
    );

    modport slave (
        input  short, long, stop,
        output t1, t2, t3, w1, w2, w3, running, int_pulse
    );

endinterface

// File: rtl/sync_edge.sv
// Brings an asynchronous button into the clk domain and reports its
// rising edges as single-clk pulses.
//   clk  : board clock
//   clr  : asynchronous active-high reset, clears every flop
//   din  : raw asynchronous input
//   rise : high for one clk after a synchronized rising edge of din
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    // Shift chain; last_q remembers the previous synchronized level so a
    // held button yields only one edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/beat_timer.sv
// Machine-cycle timing generator for the hardwired controller.
// Produces phase pulses t1..t3 and beat levels w1..w3, follows the
// controller's short/long/stop requests at the end of each beat, and
// conditions the start button and interrupt request into clean events.
//   clk       : board clock, all state on rising edge
//   clr       : asynchronous active-high reset
//   start_btn : raw start button
//   int_btn   : raw interrupt request
//   bus       : controller bundle (short/long/stop in, t/w/running/int_pulse out)
module beat_timer
    import beat_pkg::*;
#(
    parameter int PHASE_CYCLES = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int PULSE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start_btn,
    input  logic         int_btn,
    beat_timer_if.slave  bus
);

    localparam int               CNT_W    = $clog2(PHASE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [3:0]       STRETCH_INIT = 4'(PULSE_CYCLES - 1);

    state_t           state_q, state_d;
    beat_t            beat_q,  beat_d;
    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [2:0] t_q;
    logic [2:0] w_q;
    logic       run_q;

    logic [3:0] stretch_q;
    logic       int_pulse_q;

    logic start_rise;
    logic int_rise;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
        .clk  (clk),
        .clr  (clr),
        .din  (start_btn),
        .rise (start_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_int_sync (
        .clk  (clk),
        .clr  (clr),
        .din  (int_btn),
        .rise (int_rise)
    );

    // State register. The t/w/running outputs are registered from the
    // next-state values so they change exactly with the state and never
    // glitch; a halt therefore drops t3 and w on the same edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            beat_q  <= B_W1;
            phase_q <= P_T1;
            cnt_q   <= '0;
            t_q     <= 3'b000;
            w_q     <= 3'b000;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            t_q     <= (state_d == RUN) ? phase_onehot(phase_d) : 3'b000;
            w_q     <= (state_d == RUN) ? beat_onehot(beat_d)   : 3'b000;
            run_q   <= (state_d == RUN);
        end
    end

    // Next-state logic. The controller inputs are only looked at on the
    // last clk of T3, so glitches elsewhere in the beat are harmless.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, HALT: begin
                if (start_rise) begin
                    state_d = RUN;
                    beat_d  = B_W1;
                    phase_d = P_T1;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    case (phase_q)
                        P_T1:    phase_d = P_T2;
                        P_T2:    phase_d = P_T3;
                        default: begin
                            phase_d = P_T1;
                            if (bus.stop) begin
                                state_d = HALT;
                                beat_d  = B_W1;
                            end else begin
                                case (beat_q)
                                    B_W1:    beat_d = bus.short ? B_W1 : B_W2;
                                    B_W2:    beat_d = bus.long  ? B_W3 : B_W1;
                                    default: beat_d = B_W1;
                                endcase
                            end
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = B_W1;
                phase_d = P_T1;
                cnt_d   = '0;
            end
        endcase
    end

    // Interrupt stretcher. stretch_q counts the clks still to go after the
    // current one; new edges are dropped while the pulse is high.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stretch_q   <= 4'd0;
            int_pulse_q <= 1'b0;
        end else if (!int_pulse_q && int_rise) begin
            int_pulse_q <= 1'b1;
            stretch_q   <= STRETCH_INIT;
        end else if (int_pulse_q) begin
            if (stretch_q == 4'd0) begin
                int_pulse_q <= 1'b0;
            end else begin
                stretch_q <= stretch_q - 4'd1;
            end
        end
    end

    assign bus.t1        = t_q[0];
    assign bus.t2        = t_q[1];
    assign bus.t3        = t_q[2];
    assign bus.w1        = w_q[0];
    assign bus.w2        = w_q[1];
    assign bus.w3        = w_q[2];
    assign bus.running   = run_q;
    assign bus.int_pulse = int_pulse_q;

endmodule

// File: tb/tb_beat_timer.sv
// Randomized scoreboard bench for beat_timer.
// Stimulus processes push the expected beat sequence and interrupt pulse
// start times into queues; a monitor on the falling clk edge pops and
// compares whenever the DUT starts a beat, halts, or raises int_pulse.
module tb_beat_timer;

    localparam int P          = 2;
    localparam int S          = 2;
    localparam int PW         = 2;
    localparam int BEAT_CLKS  = 3 * P;

    logic clk = 1'b0;
    logic clr;
    logic start_btn;
    logic int_btn;

    beat_timer_if bus ();

    beat_timer #(
        .PHASE_CYCLES (P),
        .SYNC_STAGES  (S),
        .PULSE_CYCLES (PW)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .start_btn (start_btn),
        .int_btn   (int_btn),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected beat codes: 1..3 for W1..W3, 0 for a halt.
    int exp_beat[$];
    int exp_pulse[$];
    int plan[$];
    bit mon_en = 1'b0;
    int last_pulse = -1000;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cyc %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int w_code(input logic [2:0] w);
        if (w == 3'b001) return 1;
        if (w == 3'b010) return 2;
        if (w == 3'b100) return 3;
        return 0;
    endfunction

    // Reference rule for the beat following cur when not stopping.
    function automatic int next_beat(input int cur, input bit s, input bit l);
        if (cur == 1) return s ? 1 : 2;
        if (cur == 2) return l ? 3 : 1;
        return 1;
    endfunction

    // Monitor: beat starts, halts, phase timing and interrupt pulses.
    logic [2:0] p_t, p_w, t_now, w_now;
    bit p_run, p_int;
    int t_len, int_start;

    always @(negedge clk) begin
        t_now = {bus.t3, bus.t2, bus.t1};
        w_now = {bus.w3, bus.w2, bus.w1};
        if (!mon_en) begin
            p_run = 1'b0; p_t = 3'b000; p_w = 3'b000; t_len = 0; p_int = 1'b0;
        end else begin
            if (bus.running) begin
                checkOutput("t onehot", $countones(t_now), 1);
                checkOutput("w onehot", $countones(w_now), 1);
            end else begin
                checkOutput("stopped t/w zero", int'({t_now, w_now}), 0);
            end
            if (bus.running && bus.t1 && !(p_run && p_t == 3'b001)) begin
                if (p_run) begin
                    checkOutput("phase len", t_len, P);
                    checkOutput("phase order", int'(p_t), 4);
                end
                if (exp_beat.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("[TB] FAIL beat: got W%0d, expected no beat (cyc %0d)", w_code(w_now), cyc);
                end else begin
                    checkOutput("beat", w_code(w_now), exp_beat.pop_front());
                end
                t_len = 1;
            end else if (bus.running && p_run) begin
                checkOutput("w hold", int'(w_now), int'(p_w));
                if (t_now != p_t) begin
                    checkOutput("phase len", t_len, P);
                    checkOutput("phase order", int'(t_now), int'({p_t[1:0], p_t[2]}));
                    t_len = 1;
                end else begin
                    t_len++;
                end
            end
            if (p_run && !bus.running) begin
                checkOutput("halt phase len", t_len, P);
                checkOutput("halt from t3", int'(p_t), 4);
                if (exp_beat.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("[TB] FAIL halt: got halt, expected nothing (cyc %0d)", cyc);
                end else begin
                    checkOutput("halt", w_code(w_now), exp_beat.pop_front());
                end
            end
            if (bus.int_pulse && !p_int) begin
                if (exp_pulse.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("[TB] FAIL int start: got pulse at cyc %0d, expected none", cyc);
                end else begin
                    checkOutput("int start", cyc, exp_pulse.pop_front());
                end
                int_start = cyc;
            end
            if (!bus.int_pulse && p_int) begin
                checkOutput("int width", cyc - int_start, PW);
            end
            p_run = bus.running;
            p_t   = t_now;
            p_w   = w_now;
            p_int = bus.int_pulse;
        end
    end

    // One run from IDLE/HALT to halt. Decisions come from plan (bit0 short,
    // bit1 long, bit2 stop) or are random once plan is empty; other clks of
    // each beat get random junk on short/long/stop and, unless the button
    // is held, random start toggles early enough to land inside RUN.
    task automatic applyStimulus(input bit hold_start, input int max_beats);
        int cur, code;
        bit s, l, st, halted;
        start_btn = 1'b0;
        bus.short = 1'b0; bus.long = 1'b0; bus.stop = 1'b0;
        @(negedge clk);
        start_btn = 1'b1;
        exp_beat.push_back(1);
        repeat (2) @(negedge clk);
        checkOutput("start latency early", int'(bus.running), 0);
        @(negedge clk);
        checkOutput("start w1t1", int'(bus.w1 && bus.t1), 1);
        if (!hold_start) start_btn = 1'b0;
        cur = 1;
        halted = 1'b0;
        for (int b = 0; !halted; b++) begin
            for (int k = 0; k < BEAT_CLKS; k++) begin
                if (k == BEAT_CLKS - 1) begin
                    if (plan.size() != 0) begin
                        code = plan.pop_front();
                        s = code[0]; l = code[1]; st = code[2];
                    end else begin
                        s  = 1'($urandom);
                        l  = 1'($urandom);
                        st = ($urandom_range(0, 5) == 0);
                    end
                    if (b >= max_beats - 1) st = 1'b1;
                    bus.short = s; bus.long = l; bus.stop = st;
                    if (st) begin
                        exp_beat.push_back(0);
                        halted = 1'b1;
                    end else begin
                        cur = next_beat(cur, s, l);
                        exp_beat.push_back(cur);
                    end
                end else begin
                    bus.short = 1'($urandom);
                    bus.long  = 1'($urandom);
                    bus.stop  = 1'($urandom);
                    if (!hold_start && k <= BEAT_CLKS - 3) start_btn = 1'($urandom);
                end
                @(negedge clk);
            end
        end
        bus.short = 1'b0; bus.long = 1'b0; bus.stop = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("stays halted", int'(bus.running), 0);
    endtask

    // Raw interrupt high for hi clks then low for lo clks (lo >= 1).
    task automatic pulseInt(input int hi, input int lo);
        int e;
        int_btn = 1'b1;
        e = cyc + S;
        if (!(e >= last_pulse && e <= last_pulse + PW - 1)) begin
            last_pulse = e + 1;
            exp_pulse.push_back(last_pulse);
        end
        repeat (hi) @(negedge clk);
        int_btn = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        clr = 1'b1;
        start_btn = 1'b0;
        int_btn = 1'b0;
        bus.short = 1'b0; bus.long = 1'b0; bus.stop = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset running", int'(bus.running), 0);
        checkOutput("reset t/w", int'({bus.t3, bus.t2, bus.t1, bus.w3, bus.w2, bus.w1}), 0);
        checkOutput("reset int_pulse", int'(bus.int_pulse), 0);
        clr = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        fork
            begin
                plan = '{0, 0, 0, 4};
                applyStimulus(1'b0, 20);
                plan = '{1, 1, 0, 0, 4};
                applyStimulus(1'b0, 20);
                plan = '{2, 2, 3, 4};
                applyStimulus(1'b0, 20);
                plan = '{0, 6};
                applyStimulus(1'b1, 20);
                for (int r = 0; r < 8; r++) begin
                    plan.delete();
                    applyStimulus(1'b0, 12);
                end
            end
            begin
                repeat (3) @(negedge clk);
                pulseInt(5, 6);
                pulseInt(1, 1);
                pulseInt(1, 8);
                pulseInt(2, 6);
                for (int r = 0; r < 20; r++) begin
                    pulseInt($urandom_range(1, 4), $urandom_range(1, 4));
                end
                repeat (6) @(negedge clk);
            end
        join

        repeat (10) @(negedge clk);
        checkOutput("beat queue drained", exp_beat.size(), 0);
        checkOutput("pulse queue drained", exp_pulse.size(), 0);

        // Asynchronous clear in the middle of W2/T2.
        mon_en = 1'b0;
        start_btn = 1'b0;
        @(negedge clk);
        start_btn = 1'b1;
        repeat (3) @(negedge clk);
        start_btn = 1'b0;
        repeat (BEAT_CLKS + P) @(negedge clk);
        checkOutput("pre-clear w2t2", int'(bus.w2 && bus.t2), 1);
        #2 clr = 1'b1;
        #1 checkOutput("async clear outputs",
                       int'({bus.running, bus.t3, bus.t2, bus.t1, bus.w3, bus.w2, bus.w1}), 0);
        @(negedge clk);
        clr = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("idle after clear", int'(bus.running), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        n_fail++;
        $display("[TB] FAIL watchdog: got timeout at cyc %0d, expected completion", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/beat_timer.md
Name: beat_timer

Overview:
- Generates the machine-cycle timing consumed by the hardwired controller: phase pulses t1..t3 and beat levels w1..w3.
- Reacts to the controller's short/long/stop requests.
- Conditions the raw start button and the raw interrupt request into clean single events.
- Sits between the board clock and the controller; the controller samples its state on the falling edge of t3.

Parameters:
- PHASE_CYCLES, 4, clk cycles per T phase (legal 1..255)
- SYNC_STAGES, 2, flip-flops in each input synchronizer (legal 2..4)
- PULSE_CYCLES, 2, width in clk cycles of int_pulse (legal 1..15)

Ports:
- clk  in  1  board clock; all state on rising edge
- clr  in  1  asynchronous active-high reset (top level drives clr = ~clr_n)
- start_btn  in  1  raw start button, asynchronous, active-high
- int_btn  in  1  raw interrupt request, asynchronous, active-high
- short  in  1  controller: beat after current W1 is W1
- long  in  1  controller: beat after current W2 is W3
- stop  in  1  controller: halt after current beat
- t1, t2, t3  out  1 each  one-hot phase pulses while running
- w1, w2, w3  out  1 each  one-hot beat levels while running
- running  out  1  high in RUN state
- int_pulse  out  1  conditioned interrupt pulse, PULSE_CYCLES wide

Behaviour:
- Reset (clr high, asynchronous): state IDLE, phase counter 0, all outputs 0, synchronizer and stretch counters cleared. Effective immediately, including mid-beat.
- States:
  - IDLE: reset state.
  - RUN: beats in progress.
  - HALT: entered by stop.
- IDLE and HALT behave identically: all t/w outputs 0, running 0.
- Start handling:
  - In IDLE or HALT, a synchronized rising edge of start_btn moves the block to RUN at W1/T1 on the next clk.
  - start edges while in RUN are ignored.
  - A button held high across a halt does not restart; a new rising edge is required.
- RUN timing:
  - Each beat is T1, T2, T3, each exactly PHASE_CYCLES clks.
  - Exactly one t and exactly one w is high.
  - w holds for all 3*PHASE_CYCLES clks of its beat.
- Decision point: the last clk of T3 (t3 still high). short, long and stop are sampled there; the result takes effect on the next clk, when t3 falls.
- Next-beat rules at the decision point, priority top to bottom:
  - stop=1: go to HALT; the resume beat is always W1; short and long are ignored.
  - Current beat W1, short=1: next beat is W1.
  - Current beat W1, short=0: next beat is W2.
  - Current beat W2, long=1: next beat is W3.
  - Current beat W2, long=0: next beat is W1.
  - Current beat W3: next beat is W1.
  - long during W1, short during W2 or W3, and long during W3: ignored.
- short/long/stop outside the decision clk have no effect. Combinational glitches on them are tolerated.
- Latencies:
  - start edge to w1/t1 high: SYNC_STAGES+1 clks.
  - Halt: t3 and w fall together on the clk after the decision point.
- Interrupt:
  - A synchronized rising edge of int_btn raises int_pulse on the next clk for exactly PULSE_CYCLES clks.
  - Edges during an active pulse are ignored.
  - Interrupt handling is independent of IDLE/HALT/RUN.
- Counters:
  - Phase counter width is clog2(PHASE_CYCLES+1); it wraps to 0 at phase change.
  - Stretch counter width is 4 bits.
- Outputs are registered and glitch-free.

Decomposition:
- Package beat_pkg:
  - state enum {IDLE, RUN, HALT}
  - beat enum {B_W1, B_W2, B_W3}
  - phase enum {P_T1, P_T2, P_T3}
  - one-hot decode function for beat and phase.
- Sub-module sync_edge, instantiated twice (start_btn, int_btn):
  - SYNC_STAGES-flop synchronizer
  - rising-edge detector with a 1-clk output; reset clears all flops.

Test Plan:
- Reset and start (PHASE_CYCLES=2): reset, then start edge → w1,t1 high after 3 clks; t pattern t1,t1,t2,t2,t3,t3; w2 follows w1, then w1 again with short=long=stop=0.
- short=1 held during W1 → W1,W1,W1 repeats; drop short → W1,W2,W1.
- long=1 in W2 → W1,W2,W3,W1; long=1 only in W1 → no W3.
- stop=1 at the W2 decision clk with long=1 → halt without W3; running=0, all t/w 0; a new start edge resumes at W1/T1. Start held continuously → no restart.
- clr asserted mid-W2/T2 → all outputs 0 on the same clk edge. Start edges while running are ignored.
- int_btn 5-clk pulse (PULSE_CYCLES=2) → int_pulse high exactly 2 clks after 3 clks' latency. A second edge inside the pulse is ignored; an edge after the pulse produces a new pulse.
